// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word reads to instruction
// memory, and buffers returned words with their PCs for the decoder.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            next_instr
);
    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    // Request handshake: a request transfers on a cycle where imem_req_valid and
    // imem_req_ready are both high. valid depends only on registered state, and
    // valid/addr hold until the transfer except across a redirect, which may
    // retarget the address of a request that has not been accepted yet.

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem [FIFO_DEPTH];
    logic [PW-1:0]   head_ptr, tail_ptr, fill_ptr;
    logic [CW-1:0]   alloc_cnt, pend_cnt, drop_cnt;
    logic [CW:0]     credit_used;

    logic accept, rsp_fill, rsp_drop, pop;
    logic [CW-1:0] acc_c, pop_c, fill_c, drop_c, rsp_c;

    assign credit_used    = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    assign imem_req_valid = !rst && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;

    // Entries fill strictly in allocation order, so the head is filled exactly
    // when there are more allocated entries than unfilled ones.
    assign instr_valid = !rst && (alloc_cnt > pend_cnt);
    assign instr       = instr_valid ? data_mem[head_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[head_ptr]   : '0;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid && (drop_cnt == '0);
    assign pop      = instr_valid && next_instr;

    assign acc_c  = {{(CW-1){1'b0}}, accept};
    assign pop_c  = {{(CW-1){1'b0}}, pop};
    assign fill_c = {{(CW-1){1'b0}}, rsp_fill};
    assign drop_c = {{(CW-1){1'b0}}, rsp_drop};
    assign rsp_c  = {{(CW-1){1'b0}}, imem_rsp_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC & ALIGN_MASK;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
        end else if (redirect_valid) begin
            // Everything in flight or still unfilled becomes a response to discard.
            pc        <= redirect_pc & ALIGN_MASK;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= drop_cnt + pend_cnt + acc_c - rsp_c;
        end else begin
            if (accept) begin
                pc       <= pc + XLEN'(4);
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (rsp_fill) fill_ptr <= fill_ptr + PW'(1);
            if (pop)      head_ptr <= head_ptr + PW'(1);
            alloc_cnt <= alloc_cnt + acc_c - pop_c;
            pend_cnt  <= pend_cnt + acc_c - fill_c;
            drop_cnt  <= drop_cnt - drop_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (accept)   pc_mem[tail_ptr]   <= pc;
            if (rsp_fill) data_mem[fill_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a queue model of the buffered
// fetch stream, exercised by directed scenarios and a randomized run.
module tb_fetch_unit;
    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_valid, imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [XLEN-1:0]   imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              instr_valid;
    logic [XLEN-1:0]   instr, instr_pc;
    logic              next_instr;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .next_instr(next_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1;
    bit rsp_stall = 1'b0;

    // memory model: accepted requests awaiting their response, oldest first
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    bit          mq_stale[$];
    // fetch stream model: PCs of filled buffer entries, head first
    logic [31:0] exp_q[$];
    logic [31:0] exp_req;

    bit          m_req_valid, m_instr_valid;
    logic [31:0] m_req_addr, m_instr, m_instr_pc;
    logic        s_req_valid, s_instr_valid, s_dacc;
    logic [31:0] s_req_addr, s_instr, s_instr_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    // One clock: drive memory, settle, snapshot DUT and model, advance model at the edge.
    task automatic step();
        bit acc, pop, rsp;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc + 1 &&
            !(rsp_stall && $urandom_range(0, 3) == 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        m_req_valid   = !rst && (exp_q.size() + mq_addr.size() < DEPTH);
        m_req_addr    = exp_req;
        m_instr_valid = !rst && (exp_q.size() > 0);
        m_instr_pc    = 32'h0;
        m_instr       = 32'h0;
        if (m_instr_valid) begin
            m_instr_pc = exp_q[0];
            m_instr    = instr_of(exp_q[0]);
        end
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr       = instr;
        s_instr_pc    = instr_pc;
        s_dacc        = imem_req_valid && imem_req_ready;
        rsp = imem_rsp_valid;
        acc = m_req_valid && imem_req_ready;
        pop = m_instr_valid && next_instr && !redirect_valid;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq_addr.delete(); mq_due.delete(); mq_stale.delete();
            exp_q.delete();
            exp_req = RST_PC;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (rsp) begin
                if (!mq_stale[0] && !redirect_valid) exp_q.push_back(mq_addr[0]);
                void'(mq_addr.pop_front()); void'(mq_due.pop_front()); void'(mq_stale.pop_front());
            end
            if (redirect_valid) begin
                foreach (mq_stale[i]) mq_stale[i] = 1'b1;
                exp_q.delete();
            end
            if (acc) begin
                mq_addr.push_back(exp_req);
                mq_due.push_back(cyc + $urandom_range(lat_min, lat_max));
                mq_stale.push_back(redirect_valid);
                if (!redirect_valid) exp_req = exp_req + 32'd4;
            end
            if (redirect_valid) exp_req = redirect_pc & ~32'h3;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_req_ready = 1'b0; next_instr = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; rsp_stall = 1'b0;
        lat_min = 1; lat_max = 1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if (s_req_valid !== 1'b0 || s_instr_valid !== 1'b0 || s_instr !== 32'h0 || s_instr_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got req_valid=%b instr_valid=%b instr=%h pc=%h want 0 0 0 0",
                     s_req_valid, s_instr_valid, s_instr, s_instr_pc);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC || s_instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release got req_valid=%b addr=%h instr_valid=%b want 1 %h 0",
                     s_req_valid, s_req_addr, s_instr_valid, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] acc_addr[$], pop_pc[$], pop_ins[$];
        int acc_idx[$];
        int first_valid = -1;
        logic [31:0] want_pc[3], want_ins[3];
        want_pc  = '{32'h0, 32'h4, 32'h8};
        want_ins = '{32'h0000_0013, 32'h0010_0093, instr_of(32'h8)};
        do_reset();
        imem_req_ready = 1'b1; next_instr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_dacc) begin acc_addr.push_back(s_req_addr); acc_idx.push_back(i); end
            if (s_instr_valid) begin
                if (first_valid < 0) first_valid = i;
                pop_pc.push_back(s_instr_pc); pop_ins.push_back(s_instr);
            end
        end
        n_checks++;
        if (acc_addr.size() < 3 || pop_pc.size() < 3) begin
            n_errors++;
            $display("FAIL stream_count got accepts=%0d pops=%0d want >=3 each", acc_addr.size(), pop_pc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (acc_addr[k] !== want_pc[k] || pop_pc[k] !== want_pc[k] || pop_ins[k] !== want_ins[k]) begin
                    n_errors++;
                    $display("FAIL stream_seq[%0d] got addr=%h pc=%h instr=%h want %h %h %h",
                             k, acc_addr[k], pop_pc[k], pop_ins[k], want_pc[k], want_pc[k], want_ins[k]);
                end
            end
            n_checks++;
            if (acc_idx[1] != acc_idx[0] + 1) begin
                n_errors++;
                $display("FAIL stream_back_to_back got cycles %0d,%0d want consecutive", acc_idx[0], acc_idx[1]);
            end
            n_checks++;
            if (first_valid != acc_idx[0] + 2) begin
                n_errors++;
                $display("FAIL stream_latency got first valid cycle %0d want %0d", first_valid, acc_idx[0] + 2);
            end
        end
    endtask

    task automatic test_hold();
        int n_acc = 0;
        do_reset();
        imem_req_ready = 1'b1; next_instr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (s_dacc) n_acc++;
            if (i >= 4) begin
                n_checks++;
                if (s_req_valid !== 1'b0 || s_instr_valid !== 1'b1 || s_instr !== 32'h0000_0013 || s_instr_pc !== 32'h0) begin
                    n_errors++;
                    $display("FAIL hold_stable got req_valid=%b valid=%b instr=%h pc=%h want 0 1 00000013 00000000",
                             s_req_valid, s_instr_valid, s_instr, s_instr_pc);
                end
            end
        end
        n_checks++;
        if (n_acc != 2) begin
            n_errors++;
            $display("FAIL hold_accepts got %0d want 2", n_acc);
        end
        next_instr = 1'b1;
        step();
        next_instr = 1'b0;
        step();
        n_checks++;
        if (s_instr_valid !== 1'b1 || s_instr !== 32'h0010_0093 || s_instr_pc !== 32'h4 ||
            s_req_valid !== 1'b1 || s_req_addr !== 32'h8) begin
            n_errors++;
            $display("FAIL hold_after_pop got valid=%b instr=%h pc=%h req=%b addr=%h want 1 00100093 00000004 1 00000008",
                     s_instr_valid, s_instr, s_instr_pc, s_req_valid, s_req_addr);
        end
        step();
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_one_refill got req_valid=%b want 0", s_req_valid);
        end
    endtask

    task automatic test_redirect_drop();
        bit seen = 1'b0, req_seen = 1'b0;
        do_reset();
        lat_min = 4; lat_max = 4;
        imem_req_ready = 1'b1; next_instr = 1'b1;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (s_dacc && !req_seen) begin
                req_seen = 1'b1;
                n_checks++;
                if (s_req_addr !== 32'h100) begin
                    n_errors++;
                    $display("FAIL redirect_req_addr got %h want 00000100", s_req_addr);
                end
            end
            if (s_instr_valid) begin
                seen = 1'b1;
                n_checks++;
                if (s_instr_pc !== 32'h100 || s_instr !== instr_of(32'h100)) begin
                    n_errors++;
                    $display("FAIL redirect_first_instr got pc=%h instr=%h want 00000100 %h",
                             s_instr_pc, s_instr, instr_of(32'h100));
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL redirect_timeout got no instr_valid in 40 cycles want one");
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        imem_req_ready = 1'b1; next_instr = 1'b0;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h203; next_instr = 1'b1;
        step();
        n_checks++;
        if (s_instr_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL collide_setup got instr_valid=%b rsp=%b want 1 1", s_instr_valid, imem_rsp_valid);
        end
        redirect_valid = 1'b0; next_instr = 1'b0;
        step();
        n_checks++;
        if (s_instr_valid !== 1'b0 || s_instr !== 32'h0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL collide_after got valid=%b instr=%h req=%b addr=%h want 0 00000000 1 00000200",
                     s_instr_valid, s_instr, s_req_valid, s_req_addr);
        end
        step(); step();
        n_checks++;
        if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h200) begin
            n_errors++;
            $display("FAIL collide_refetch got valid=%b pc=%h want 1 00000200", s_instr_valid, s_instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] acc_addr[$], pop_pc[$], pop_ins[$];
        do_reset();
        imem_req_ready = 1'b1; next_instr = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_dacc) acc_addr.push_back(s_req_addr);
            if (s_instr_valid) begin pop_pc.push_back(s_instr_pc); pop_ins.push_back(s_instr); end
        end
        n_checks++;
        if (acc_addr.size() < 2 || pop_pc.size() < 2) begin
            n_errors++;
            $display("FAIL wrap_count got accepts=%0d pops=%0d want >=2 each", acc_addr.size(), pop_pc.size());
        end else begin
            n_checks++;
            if (acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0) begin
                n_errors++;
                $display("FAIL wrap_req got %h,%h want fffffffc,00000000", acc_addr[0], acc_addr[1]);
            end
            n_checks++;
            if (pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0 ||
                pop_ins[0] !== instr_of(32'hFFFF_FFFC) || pop_ins[1] !== 32'h0000_0013) begin
                n_errors++;
                $display("FAIL wrap_instr got pc=%h,%h instr=%h,%h want fffffffc,00000000 %h,00000013",
                         pop_pc[0], pop_pc[1], pop_ins[0], pop_ins[1], instr_of(32'hFFFF_FFFC));
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        imem_req_ready = 1'b1; next_instr = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        n_checks++;
        if (s_instr_valid !== 1'b0 || s_instr !== 32'h0 || s_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midop_in_reset got valid=%b instr=%h req=%b want 0 00000000 0",
                     s_instr_valid, s_instr, s_req_valid);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (s_instr_valid !== 1'b0 || s_instr !== 32'h0 || s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
            n_errors++;
            $display("FAIL midop_release got valid=%b instr=%h req=%b addr=%h want 0 00000000 1 %h",
                     s_instr_valid, s_instr, s_req_valid, s_req_addr, RST_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 4; rsp_stall = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            next_instr     = $urandom_range(0, 1) == 1;
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                         : 32'($urandom_range(0, 32'h3FF));
            rst            = ($urandom_range(0, 149) == 0);
            step();
            n_checks++;
            if (s_req_valid !== m_req_valid) begin
                n_errors++;
                $display("FAIL rand_req_valid cyc %0d got %b want %b", cyc, s_req_valid, m_req_valid);
            end
            if (m_req_valid) begin
                n_checks++;
                if (s_req_addr !== m_req_addr) begin
                    n_errors++;
                    $display("FAIL rand_req_addr cyc %0d got %h want %h", cyc, s_req_addr, m_req_addr);
                end
            end
            n_checks++;
            if (s_instr_valid !== m_instr_valid || s_instr_pc !== m_instr_pc || s_instr !== m_instr) begin
                n_errors++;
                $display("FAIL rand_instr cyc %0d got valid=%b pc=%h instr=%h want %b %h %h",
                         cyc, s_instr_valid, s_instr_pc, s_instr, m_instr_valid, m_instr_pc, m_instr);
            end
        end
        rst = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; next_instr = 1'b0;
        exp_req = RST_PC;
        @(negedge clk);
        test_reset();
        test_stream();
        test_hold();
        test_redirect_drop();
        test_redirect_collide();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
